data_memory_ctrl: RTL and testbench

Parametrised byte-addressable data memory with a request/ready/valid handshake, used as the data-side memory of the microarchitecture. It is the successor to the single-cycle data memory and adds byte, halfword and word accesses, signed/unsigned load extension, and a configurable number of wait states. Accesses that cross a 4-byte word boundary are split automatically into two internal word cycles. Out-of-range and illegal-size accesses are flagged with an error.

---
 rtl/data_memory_ctrl.sv | 164 ++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - byte-addressable data memory with wait states, split word-crossing accesses and error flagging
module data_memory_ctrl #(
    parameter int SIZE     = 32,
    parameter int OFFSET   = 50,
    parameter int READ_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Signed,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic        Ready,
    output logic        Valid,
    output logic [31:0] RD,
    output logic        Err
);

    localparam int NBYTES = SIZE * 4;
    localparam int AW     = $clog2(NBYTES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SECOND, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_mem [NBYTES];
    logic [2:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_ea;
    logic [31:0] r_wd;
    logic [31:0] r_buf;
    logic [31:0] r_rd;
    logic        r_err;

    logic [2:0]    w_nb;
    logic [32:0]   w_last;
    logic          w_err;
    logic          w_cross;
    logic          w_acc_first;
    logic          w_acc_second;
    logic          w_accept;
    logic          w_enter_resp;
    logic [3:0]    w_sel;
    logic [AW-1:0] w_idx [4];
    logic [31:0]   w_buf_next;
    logic [31:0]   w_ext;

    always_comb begin
        case (r_size)
            2'b00:   w_nb = 3'd1;
            2'b01:   w_nb = 3'd2;
            default: w_nb = 3'd4;
        endcase
    end

    // 33-bit sum so an effective address near 2^32 cannot wrap into range
    assign w_last  = {1'b0, r_ea} + {30'd0, w_nb} - 33'd1;
    assign w_err   = (r_size == 2'b11) || (w_last >= 33'(NBYTES));
    assign w_cross = ({1'b0, r_ea[1:0]} + w_nb) > 3'd4;

    always_comb begin
        w_state_next = r_state;
        Ready        = 1'b0;
        Valid        = 1'b0;
        w_acc_first  = 1'b0;
        w_acc_second = 1'b0;
        case (r_state)
            S_IDLE: begin
                Ready = 1'b1;
                if (EN && Req) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (EN && r_cnt == 3'd0) begin
                    w_acc_first  = 1'b1;
                    w_state_next = (w_cross && !w_err) ? S_SECOND : S_RESP;
                end
            end
            S_SECOND: begin
                if (EN) begin
                    w_acc_second = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                Valid = 1'b1;
                if (EN) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_accept     = (r_state == S_IDLE) && EN && Req;
    assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);

    // Lane i of the access lives in EA's word when (EA mod 4) + i < 4, else in the next word
    always_comb begin
        w_buf_next = r_buf;
        for (int i = 0; i < 4; i++) begin
            w_idx[i] = r_ea[AW-1:0] + AW'(i);
            w_sel[i] = !w_err && (i < int'(w_nb)) &&
                       ((w_acc_first  && (int'(r_ea[1:0]) + i < 4)) ||
                        (w_acc_second && (int'(r_ea[1:0]) + i >= 4)));
            if (w_sel[i]) w_buf_next[8*i +: 8] = r_mem[w_idx[i]];
        end
    end

    always_comb begin
        case (r_size)
            2'b00:   w_ext = {{24{r_signed & w_buf_next[7]}},  w_buf_next[7:0]};
            2'b01:   w_ext = {{16{r_signed & w_buf_next[15]}}, w_buf_next[15:0]};
            default: w_ext = w_buf_next;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NBYTES; i++) r_mem[i] <= 8'd0;
            r_cnt    <= 3'd0;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_ea     <= 32'd0;
            r_wd     <= 32'd0;
            r_buf    <= 32'd0;
            r_rd     <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= MemWrite;
                r_size   <= Size;
                r_signed <= Signed;
                r_ea     <= A + 32'(OFFSET);
                r_wd     <= WD;
                r_buf    <= 32'd0;
                r_cnt    <= 3'(READ_LAT - 1);
            end
            if (r_state == S_WAIT && EN && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
            if (r_we) begin
                for (int i = 0; i < 4; i++)
                    if (w_sel[i]) r_mem[w_idx[i]] <= r_wd[8*i +: 8];
            end else begin
                r_buf <= w_buf_next;
            end
            if (w_enter_resp) begin
                r_rd  <= (w_err || r_we) ? 32'd0 : w_ext;
                r_err <= w_err;
            end
        end
    end

    assign RD  = r_rd;
    assign Err = r_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - table-driven bench for data_memory_ctrl at READ_LAT 1 and 3
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        req1 = 1'b0;
    logic        req3 = 1'b0;
    logic        mw = 1'b0;
    logic [1:0]  sz = 2'b00;
    logic        sgn = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] wd = 32'd0;
    logic        ready1, valid1, err1, ready3, valid3, err3;
    logic [31:0] rd1, rd3;

    int cur = 1;
    int n_cmp = 0;
    int n_bad = 0;

    logic        c_ready, c_valid, c_err;
    logic [31:0] c_rd;
    assign c_ready = (cur == 3) ? ready3 : ready1;
    assign c_valid = (cur == 3) ? valid3 : valid1;
    assign c_err   = (cur == 3) ? err3   : err1;
    assign c_rd    = (cur == 3) ? rd3    : rd1;

    always #5 clk = ~clk;

    data_memory_ctrl #(.SIZE(32), .OFFSET(50), .READ_LAT(1)) dut1 (
        .CLK(clk), .RST(rst), .EN(en), .Req(req1), .MemWrite(mw), .Size(sz),
        .Signed(sgn), .A(a), .WD(wd), .Ready(ready1), .Valid(valid1), .RD(rd1), .Err(err1)
    );

    data_memory_ctrl #(.SIZE(32), .OFFSET(50), .READ_LAT(3)) dut3 (
        .CLK(clk), .RST(rst), .EN(en), .Req(req3), .MemWrite(mw), .Size(sz),
        .Signed(sgn), .A(a), .WD(wd), .Ready(ready3), .Valid(valid3), .RD(rd3), .Err(err3)
    );

    typedef struct {
        int          sel;
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          gap;
        logic        poke;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic access(input string tag, input vec_t v);
        int n;
        int rl;
        int g;
        int extra;
        logic got;
        cur = v.sel;
        @(negedge clk);
        g = 0;
        while (!c_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        mw = v.we; sz = v.sz; sgn = v.sg; a = v.a; wd = v.wd;
        if (v.sel == 3) req3 = 1'b1; else req1 = 1'b1;
        @(posedge clk); #1;
        if (!v.poke) begin req1 = 1'b0; req3 = 1'b0; end
        a = $urandom; wd = $urandom; mw = ~mw; sz = ~sz; sgn = ~sgn;
        if (v.gap > 0) en = 1'b0;
        rl = c_ready ? 0 : 1;
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (n == v.gap) en = 1'b1;
            if (!c_ready) rl++;
            if (c_valid) got = 1'b1;
        end
        en = 1'b1; req1 = 1'b0; req3 = 1'b0;
        chk({tag, "_lat"}, n, v.lat);
        chk({tag, "_rd"}, c_rd, v.rd);
        chk({tag, "_err"}, {31'd0, c_err}, {31'd0, v.err});
        chk({tag, "_ready_low"}, rl, v.lat + 1);
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'd0, c_valid, c_ready}, 32'd1);
        if (v.poke) begin
            extra = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (c_valid) extra++;
            end
            chk({tag, "_no_extra_valid"}, extra, 0);
        end
    endtask

    initial begin
        int extra;
        vt[0]  = '{1, 1'b1, 2'd2, 1'b0, 32'd0,  32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1'b0};
        vt[1]  = '{1, 1'b0, 2'd2, 1'b0, 32'd0,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 1'b0};
        vt[2]  = '{1, 1'b1, 2'd0, 1'b0, 32'd4,  32'h00000080, 32'h0,        1'b0, 1, 0, 1'b0};
        vt[3]  = '{1, 1'b0, 2'd0, 1'b1, 32'd4,  32'h0,        32'hFFFFFF80, 1'b0, 1, 0, 1'b0};
        vt[4]  = '{1, 1'b0, 2'd0, 1'b0, 32'd4,  32'h0,        32'h00000080, 1'b0, 1, 0, 1'b0};
        vt[5]  = '{1, 1'b0, 2'd0, 1'b0, 32'd3,  32'h0,        32'h000000DE, 1'b0, 1, 0, 1'b0};
        vt[6]  = '{1, 1'b0, 2'd0, 1'b0, 32'd5,  32'h0,        32'h00000000, 1'b0, 1, 0, 1'b0};
        vt[7]  = '{1, 1'b0, 2'd1, 1'b1, 32'd1,  32'h0,        32'hFFFFADBE, 1'b0, 2, 0, 1'b0};
        vt[8]  = '{1, 1'b1, 2'd2, 1'b0, 32'd72, 32'h11223344, 32'h0,        1'b0, 2, 0, 1'b0};
        vt[9]  = '{1, 1'b1, 2'd2, 1'b0, 32'd76, 32'hCAFEBABE, 32'h0,        1'b1, 1, 0, 1'b0};
        vt[10] = '{1, 1'b0, 2'd1, 1'b0, 32'd76, 32'h0,        32'h00000000, 1'b0, 1, 0, 1'b0};
        vt[11] = '{1, 1'b0, 2'd0, 1'b0, 32'd75, 32'h0,        32'h00000011, 1'b0, 1, 0, 1'b0};
        vt[12] = '{1, 1'b0, 2'd3, 1'b0, 32'd0,  32'h0,        32'h0,        1'b1, 1, 0, 1'b0};
        vt[13] = '{1, 1'b0, 2'd0, 1'b0, 32'd77, 32'h0,        32'h00000000, 1'b0, 1, 0, 1'b0};
        vt[14] = '{1, 1'b0, 2'd0, 1'b0, 32'd78, 32'h0,        32'h0,        1'b1, 1, 0, 1'b0};
        vt[15] = '{3, 1'b1, 2'd1, 1'b0, 32'd2,  32'hABCD1234, 32'h0,        1'b0, 3, 0, 1'b0};
        vt[16] = '{3, 1'b0, 2'd1, 1'b0, 32'd2,  32'h0,        32'h00001234, 1'b0, 3, 0, 1'b0};
        vt[17] = '{3, 1'b0, 2'd2, 1'b0, 32'd0,  32'h0,        32'h12340000, 1'b0, 4, 0, 1'b0};
        vt[18] = '{3, 1'b0, 2'd1, 1'b0, 32'd2,  32'h0,        32'h00001234, 1'b0, 5, 2, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_dut1", {ready1, valid1, err1, rd1[28:0]}, {3'b100, 29'd0});
        chk("reset_dut3", {ready3, valid3, err3, rd3[28:0]}, {3'b100, 29'd0});
        chk("reset_rd", rd1 | rd3, 32'd0);

        for (int i = 0; i < 19; i++) access($sformatf("v%0d", i), vt[i]);

        // reset during the second half of a split write
        access("pre_reset_read", '{1, 1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 1'b0});
        cur = 1;
        @(negedge clk);
        mw = 1'b1; sz = 2'd2; a = 32'd0; wd = 32'h12345678; req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_reset_state", {29'd0, ready1, valid1, err1}, 32'd4);
        chk("mid_reset_rd", rd1, 32'd0);
        access("post_reset_read", '{1, 1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 32'h0, 1'b0, 2, 0, 1'b0});

        // reset and request on the same edge: the request is dropped
        @(negedge clk);
        mw = 1'b0; sz = 2'd2; a = 32'd0; rst = 1'b1; req1 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req1 = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (valid1) extra++;
        end
        chk("rst_req_dropped", extra, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
